// File: rtl/host_link.sv
// Host-side endpoint of the coprocessor serial link: sends one instruction frame over 8N1 UART and optionally collects one response frame.
// Optional response timeout is built only when HOST_LINK_TIMEOUT_EN is defined.
module host_link #(
`ifdef SIMULATION
    parameter int BAUDRATE       = 5,
`else
    parameter int BAUDRATE       = 434,
`endif
    parameter int MATRIX_N       = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      send,
    input  logic                      expect_resp,
    input  logic [8+32*MATRIX_N-1:0]  send_data,
    input  logic                      rx,
    output logic                      tx,
    output logic                      busy,
    output logic                      send_done,
    output logic                      resp_valid,
    output logic [8+32*MATRIX_N-1:0]  resp_data,
    output logic                      timeout_err
);

    localparam int FW = 8 + 32 * MATRIX_N;
    localparam int NB = FW / 8;
    localparam int BW = $clog2(NB);
    localparam int CW = $clog2(BAUDRATE);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUDRATE - 1);
    localparam logic [CW-1:0] BIT_HALF  = CW'(BAUDRATE / 2);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);
    localparam logic [BW-1:0] BYTE_END  = BW'(NB);
`ifdef HOST_LINK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TX_BYTE   = 2'd1,
        RESP_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RX_HUNT  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Line level for bit slot 0 (start), 1..8 (data LSB first) and 9 (stop).
    function automatic logic tx_level(input logic [3:0] bit_idx, input logic [7:0] data);
        logic [7:0] shifted;
        shifted = data >> (bit_idx - 4'd1);
        case (bit_idx)
            4'd0:    tx_level = 1'b0;
            4'd9:    tx_level = 1'b1;
            default: tx_level = shifted[0];
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [3:0]        tx_bit_q, tx_bit_d;
    logic [BW-1:0]     tx_byte_q, tx_byte_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              send_done_q, send_done_d;

    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e         rx_state_q, rx_state_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              rx_byte_ok_s;
    logic              accept_byte_s;

    logic              armed_q, armed_d;
    logic [BW-1:0]     rbyte_q, rbyte_d;
    logic [FW-1:0]     stage_q, stage_d;
    logic [FW-1:0]     resp_data_q, resp_data_d;
    logic              resp_valid_q, resp_valid_d;
`ifdef HOST_LINK_TIMEOUT_EN
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic              timeout_q, timeout_d;
`endif

    // Next-state logic for transmitter FSM, receiver, collector and outputs.
    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        tx_cnt_d      = tx_cnt_q;
        tx_bit_d      = tx_bit_q;
        tx_byte_d     = tx_byte_q;
        send_done_d   = 1'b0;
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_byte_ok_s  = 1'b0;
        accept_byte_s = 1'b0;
        armed_d       = armed_q;
        rbyte_d       = rbyte_q;
        stage_d       = stage_q;
        resp_data_d   = resp_data_q;
        resp_valid_d  = 1'b0;
`ifdef HOST_LINK_TIMEOUT_EN
        to_cnt_d      = '0;
        timeout_d     = 1'b0;
`endif

        case (rx_state_q)
            RX_HUNT: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end else begin
                    rx_state_d = RX_HUNT;
                end
            end
            RX_START: begin
                // A line that is high again at mid start bit was a glitch.
                if (rx_cnt_q == BIT_HALF) begin
                    rx_cnt_d = '0;
                    rx_bit_d = 3'd0;
                    if (!rx_sync_q) begin
                        rx_state_d = RX_DATA;
                    end else begin
                        rx_state_d = RX_HUNT;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_state_d   = RX_HUNT;
                    rx_cnt_d     = '0;
                    rx_byte_ok_s = rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = RX_HUNT;
        endcase

        if (rx_byte_ok_s && armed_q) begin
            accept_byte_s = 1'b1;
            stage_d[FW-1-8*int'(rbyte_q) -: 8] = rx_shift_q;
            if (rbyte_q == BYTE_LAST) begin
                resp_data_d  = stage_d;
                resp_valid_d = 1'b1;
                armed_d      = 1'b0;
                rbyte_d      = '0;
            end else if (rbyte_q != BYTE_END) begin
                rbyte_d = rbyte_q + BW'(1);
            end else begin
                rbyte_d = rbyte_q;
            end
        end else begin
            accept_byte_s = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (send && !busy_q) begin
                    state_d   = TX_BYTE;
                    frame_d   = send_data;
                    armed_d   = expect_resp;
                    rbyte_d   = '0;
                    tx_cnt_d  = '0;
                    tx_bit_d  = 4'd0;
                    tx_byte_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            TX_BYTE: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        tx_bit_d = 4'd0;
                        frame_d  = frame_q << 8;
                        if (tx_byte_q == BYTE_LAST) begin
                            send_done_d = 1'b1;
                            tx_byte_d   = BYTE_END;
                            // A response finishing on this same edge already cleared armed_d.
                            state_d     = armed_d ? RESP_WAIT : IDLE;
                        end else begin
                            tx_byte_d = tx_byte_q + BW'(1);
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            RESP_WAIT: begin
`ifdef HOST_LINK_TIMEOUT_EN
                to_cnt_d = accept_byte_s ? '0 : to_cnt_q + TW'(1);
                if (armed_d && (to_cnt_q == TO_LAST)) begin
                    timeout_d = 1'b1;
                    armed_d   = 1'b0;
                    rbyte_d   = '0;
                end else begin
                    timeout_d = 1'b0;
                end
`endif
                if (!armed_d) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP_WAIT;
                end
            end
            default: state_d = IDLE;
        endcase

        tx_d   = (state_d == TX_BYTE) ? tx_level(tx_bit_d, frame_d[FW-1 -: 8]) : 1'b1;
        // Busy spans the completion pulse cycle so callers see it high alongside the pulse.
        busy_d = (state_d != IDLE) || send_done_d || resp_valid_d;
`ifdef HOST_LINK_TIMEOUT_EN
        busy_d = busy_d || timeout_d;
`endif
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            frame_q      <= '0;
            tx_cnt_q     <= '0;
            tx_bit_q     <= 4'd0;
            tx_byte_q    <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            send_done_q  <= 1'b0;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_HUNT;
            rx_cnt_q     <= '0;
            rx_bit_q     <= 3'd0;
            rx_shift_q   <= 8'h00;
            armed_q      <= 1'b0;
            rbyte_q      <= '0;
            stage_q      <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
`ifdef HOST_LINK_TIMEOUT_EN
            to_cnt_q     <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_byte_q    <= tx_byte_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            send_done_q  <= send_done_d;
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            armed_q      <= armed_d;
            rbyte_q      <= rbyte_d;
            stage_q      <= stage_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
`ifdef HOST_LINK_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign send_done  = send_done_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
`ifdef HOST_LINK_TIMEOUT_EN
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_host_link.sv
// Directed bench for host_link at MATRIX_N=4, BAUDRATE=5 (17-byte frames, 850 line cycles per frame).
module tb_host_link;

    localparam int FW   = 136;
    localparam int BAUD = 5;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          send = 1'b0;
    logic          expect_resp = 1'b0;
    logic [FW-1:0] send_data = '0;
    logic          rx_drv = 1'b1;
    logic          loop_en = 1'b0;
    logic          rx;
    logic          tx, busy, send_done, resp_valid, timeout_err;
    logic [FW-1:0] resp_data;

    assign rx = loop_en ? tx : rx_drv;

    host_link #(.BAUDRATE(BAUD), .MATRIX_N(4), .TIMEOUT_CYCLES(200)) dut (
        .clk(clk), .resetn(resetn), .send(send), .expect_resp(expect_resp),
        .send_data(send_data), .rx(rx), .tx(tx), .busy(busy), .send_done(send_done),
        .resp_valid(resp_valid), .resp_data(resp_data), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int rv_cnt = 0;
    int te_cnt = 0;

    always @(posedge clk) begin
        if (resetn && resp_valid) rv_cnt <= rv_cnt + 1;
        if (resetn && timeout_err) te_cnt <= te_cnt + 1;
    end

    task automatic chkw(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives send for one edge; the next negedge after return is cycle accept+1.
    task automatic do_send(input logic [FW-1:0] d, input logic er);
        @(negedge clk);
        send_data   = d;
        expect_resp = er;
        send        = 1'b1;
        @(posedge clk);
        #1;
        send = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] d, input logic stop);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            rx_drv = (j == 0) ? 1'b0 : (j == 9) ? stop : d[j-1];
            repeat (BAUD - 1) @(negedge clk);
        end
    endtask

    task automatic wait_send_done(input int budget, output int at);
        at = -1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (send_done) begin
                at = n;
                break;
            end
        end
    endtask

    task automatic run_until_idle(input int budget, output int sd_at, output int rv_at, output int idle_at);
        sd_at = -1; rv_at = -1; idle_at = -1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (send_done && sd_at < 0) sd_at = n;
            if (resp_valid && rv_at < 0) rv_at = n;
            if (!busy) begin
                idle_at = n;
                break;
            end
        end
    endtask

    initial begin
        logic [FW-1:0] frame_a, frame_b, frame_c, frame_d, frame_x, rec;
        logic [7:0]    cur;
        logic          start_ok, stop_ok;
        int            sd_at, rv_at, idle_at, rv0, later, p;

        frame_a = {8'h01, 64'h0001_0002_0003_0004, 64'h0001_0002_0003_0004};
        frame_b = {8'hA5, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
        frame_c = {8'h3C, 128'h1111_2222_3333_4444_5555_6666_7777_8888};
        frame_d = {8'h5A, 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0};
        frame_x = {8'h7E, 128'hC3C3_C3C3_C3C3_C3C3_C3C3_C3C3_C3C3_C3C3};

        // Reset state
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chkb("reset_tx", tx, 1'b1);
        chkb("reset_busy", busy, 1'b0);
        chkb("reset_send_done", send_done, 1'b0);
        chkb("reset_resp_valid", resp_valid, 1'b0);
        chkb("reset_timeout", timeout_err, 1'b0);
        chkw("reset_resp_data", resp_data, '0);

        // Plain send, line capture, and an ignored send at accept+100
        do_send(frame_a, 1'b0);
        rec = '0; cur = 8'h00; start_ok = 1'b1; stop_ok = 1'b1;
        for (int n = 1; n <= 852; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chkb("first_start_bit", tx, 1'b0);
                chkb("busy_after_accept", busy, 1'b1);
            end
            if (n <= 850 && ((n - 1) % BAUD) == 2) begin
                p = (n - 1) / BAUD;
                if ((p % 10) == 0) start_ok = start_ok & (tx == 1'b0);
                else if ((p % 10) == 9) begin
                    stop_ok = stop_ok & (tx == 1'b1);
                    rec = {rec[FW-9:0], cur};
                end else cur[(p % 10) - 1] = tx;
            end
            if (n == 850) chkb("send_done_early", send_done, 1'b0);
            if (n == 851) begin
                chkb("send_done_at_851", send_done, 1'b1);
                chkb("busy_at_851", busy, 1'b1);
            end
            if (n == 852) begin
                chkb("busy_at_852", busy, 1'b0);
                chkb("send_done_single", send_done, 1'b0);
            end
            if (n == 100) begin
                send_data   = frame_x;
                expect_resp = 1'b1;
                send        = 1'b1;
            end
            if (n == 101) send = 1'b0;
        end
        chkw("first_byte_opcode", {128'h0, rec[FW-1 -: 8]}, {128'h0, 8'h01});
        chkw("line_frame", rec, frame_a);
        chkb("start_bits", start_ok, 1'b1);
        chkb("stop_bits", stop_ok, 1'b1);
        repeat (20) @(negedge clk);
        chkb("ignored_send_idle", busy, 1'b0);

        // Full-duplex loopback
        rv0 = rv_cnt;
        loop_en = 1'b1;
        do_send(frame_b, 1'b1);
        run_until_idle(2000, sd_at, rv_at, idle_at);
        loop_en = 1'b0;
        chki("loop_send_done", sd_at, 851);
        later = (sd_at > rv_at) ? sd_at : rv_at;
        chki("loop_busy_fall", idle_at, later + 1);
        chki("loop_resp_count", rv_cnt - rv0, 1);
        chkw("loop_resp_data", resp_data, frame_b);

        // Framing error dropped, then 17 good bytes
        do_send(frame_c, 1'b1);
        wait_send_done(1000, sd_at);
        chki("fe_send_done", sd_at, 851);
        rv0 = rv_cnt;
        rx_byte(8'h55, 1'b0);
        rx_drv = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 16; i++) rx_byte(frame_d[FW-1-8*i -: 8], 1'b1);
        rx_drv = 1'b1;
        repeat (10) @(negedge clk);
        chki("fe_no_early_resp", rv_cnt - rv0, 0);
        chkb("fe_busy_waiting", busy, 1'b1);
        rx_byte(frame_d[7:0], 1'b1);
        rx_drv = 1'b1;
        repeat (15) @(negedge clk);
        chki("fe_resp_count", rv_cnt - rv0, 1);
        chkw("fe_resp_data", resp_data, frame_d);
        chkb("fe_busy_done", busy, 1'b0);

        // Bytes arriving while unarmed are discarded
        rv0 = rv_cnt;
        for (int i = 0; i < 17; i++) rx_byte(8'h99, 1'b1);
        rx_drv = 1'b1;
        repeat (15) @(negedge clk);
        chki("unarmed_resp_count", rv_cnt - rv0, 0);
        chkw("unarmed_resp_data", resp_data, frame_d);

`ifdef HOST_LINK_TIMEOUT_EN
        do_send(frame_a, 1'b1);
        wait_send_done(1000, sd_at);
        chki("to_send_done", sd_at, 851);
        p = -1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (timeout_err) begin
                p = n;
                break;
            end
        end
        chki("timeout_delay", p, 200);
        @(negedge clk);
        chkb("timeout_busy_low", busy, 1'b0);
        chkb("timeout_single", timeout_err, 1'b0);
        chkw("timeout_resp_data", resp_data, frame_d);
`else
        chki("timeout_never", te_cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
